// File: rtl/uart_cmd_rx_pkg.sv
// Shared types and derived timing for the host-to-board UART command receiver.
package uart_cmd_rx_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    P_HUNT,
    P_GOT_HDR,
    P_GOT_ADDR,
    P_GOT_DATA,
    P_HOLD
  } parser_state_t;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned calc_timeout_cycles(input int unsigned timeout_bits,
                                                      input int unsigned clks_per_bit);
    return timeout_bits * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// RXD synchroniser and 8N1 byte receiver; emits one-cycle byte or framing-error pulses.
module uart_rx_byte
  import uart_cmd_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       RXD,
  output logic [7:0] RX_BYTE,
  output logic       RX_VALID,
  output logic       RX_FERR
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state;
  logic             rxd_meta;
  logic             rxd_sync;
  logic             rxd_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Start-bit check at mid-bit, then one sample per bit period; returns to idle mid-stop-bit.
  always_ff @(posedge SYS_CLK) begin
    if (!RST_N) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      RX_BYTE  <= '0;
      RX_VALID <= 1'b0;
      RX_FERR  <= 1'b0;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      RX_VALID <= 1'b0;
      RX_FERR  <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rxd_prev && !rxd_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxd_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rxd_sync) begin
              RX_VALID <= 1'b1;
              RX_BYTE  <= shreg;
            end else begin
              RX_FERR <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: parses AA/addr/data/xor packets into register-write commands.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned TIMEOUT_BITS = 20,
  parameter logic [7:0]  HEADER       = HEADER_DEFAULT
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       RXD,
  input  logic       CMD_READY,
  output logic       CMD_VALID,
  output logic [7:0] CMD_ADDR,
  output logic [7:0] CMD_DATA,
  output logic       FRAME_ERR,
  output logic       CHK_ERR,
  output logic       OVERRUN
);

  localparam int unsigned CLKS_PER_BIT   = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned TIMEOUT_CYCLES = calc_timeout_cycles(TIMEOUT_BITS, CLKS_PER_BIT);
  localparam int unsigned GAP_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_ferr;
  parser_state_t state;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic [GAP_W-1:0] gap;
  logic          in_packet;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .SYS_CLK (SYS_CLK),
    .RST_N   (RST_N),
    .RXD     (RXD),
    .RX_BYTE (rx_byte),
    .RX_VALID(rx_valid),
    .RX_FERR (rx_ferr)
  );

  assign FRAME_ERR = rx_ferr;
  assign in_packet = (state == P_GOT_HDR) || (state == P_GOT_ADDR) || (state == P_GOT_DATA);

  // Packet parser with inter-byte gap timer and output handshake hold.
  always_ff @(posedge SYS_CLK) begin
    if (!RST_N) begin
      state     <= P_HUNT;
      addr_q    <= '0;
      data_q    <= '0;
      gap       <= '0;
      CMD_VALID <= 1'b0;
      CMD_ADDR  <= '0;
      CMD_DATA  <= '0;
      CHK_ERR   <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      CHK_ERR <= 1'b0;
      OVERRUN <= 1'b0;

      if (in_packet && !rx_valid) gap <= (gap == GAP_LIMIT) ? gap : gap + 1'b1;
      else                        gap <= '0;

      unique case (state)
        P_HUNT: begin
          if (rx_valid && rx_byte == HEADER) state <= P_GOT_HDR;
        end
        P_GOT_HDR: begin
          if (rx_valid) begin
            addr_q <= rx_byte;
            state  <= P_GOT_ADDR;
          end else if (rx_ferr || gap == GAP_LIMIT) begin
            state <= P_HUNT;
          end
        end
        P_GOT_ADDR: begin
          if (rx_valid) begin
            data_q <= rx_byte;
            state  <= P_GOT_DATA;
          end else if (rx_ferr || gap == GAP_LIMIT) begin
            state <= P_HUNT;
          end
        end
        P_GOT_DATA: begin
          if (rx_valid) begin
            if (rx_byte == (addr_q ^ data_q)) begin
              CMD_VALID <= 1'b1;
              CMD_ADDR  <= addr_q;
              CMD_DATA  <= data_q;
              state     <= P_HOLD;
            end else begin
              CHK_ERR <= 1'b1;
              state   <= P_HUNT;
            end
          end else if (rx_ferr || gap == GAP_LIMIT) begin
            state <= P_HUNT;
          end
        end
        P_HOLD: begin
          // Bytes arriving while a command is pending (including the accept cycle) are lost.
          if (rx_valid) OVERRUN <= 1'b1;
          if (CMD_VALID && CMD_READY) begin
            CMD_VALID <= 1'b0;
            state     <= P_HUNT;
          end
        end
        default: state <= P_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with a packet-level scoreboard checked every cycle.
module tb_uart_cmd_rx;

  localparam int unsigned CLK_FREQ     = 1600000;
  localparam int unsigned BAUD_RATE    = 100000;
  localparam int unsigned CPB          = 16;
  localparam int unsigned TIMEOUT_BITS = 20;
  localparam logic [7:0]  HDR          = 8'hAA;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       frame_err;
  logic       chk_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_cmd_rx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE),
    .TIMEOUT_BITS(TIMEOUT_BITS),
    .HEADER      (HDR)
  ) dut (
    .SYS_CLK  (clk),
    .RST_N    (rst_n),
    .RXD      (rxd),
    .CMD_READY(cmd_ready),
    .CMD_VALID(cmd_valid),
    .CMD_ADDR (cmd_addr),
    .CMD_DATA (cmd_data),
    .FRAME_ERR(frame_err),
    .CHK_ERR  (chk_err),
    .OVERRUN  (overrun)
  );

  int checks = 0;
  int failures = 0;

  // Packet-level model state
  logic [15:0] exp_q[$];
  logic [7:0]  pkt[$];
  bit          pending = 1'b0;
  int          exp_ferr = 0, exp_chk = 0, exp_ovr = 0;
  int          cmd_seen = 0, ferr_seen = 0, chk_seen = 0, ovr_seen = 0;
  logic [7:0]  last_addr = 8'h00, last_data = 8'h00;
  bit          prev_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    pkt.delete();
    pending  = 1'b0;
    exp_ferr = 0;
    exp_chk  = 0;
    exp_ovr  = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) begin
      exp_ferr++;
      if (!pending) pkt.delete();
      return;
    end
    if (pending) begin
      exp_ovr++;
      return;
    end
    if (pkt.size() == 0) begin
      if (b == HDR) pkt.push_back(b);
      return;
    end
    pkt.push_back(b);
    if (pkt.size() == 4) begin
      if ((pkt[1] ^ pkt[2]) == pkt[3]) begin
        exp_q.push_back({pkt[1], pkt[2]});
        pending = 1'b1;
      end else begin
        exp_chk++;
      end
      pkt.delete();
    end
  endfunction

  // Per-cycle compare against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_acc = 1'b0;
    end else begin
      if (prev_acc) chk("valid_drop_after_accept", 32'(cmd_valid), 32'd0);
      prev_acc = 1'b0;
      if (cmd_valid) begin
        chk("cmd_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("cmd_payload", 32'({cmd_addr, cmd_data}), 32'(exp_q[0]));
        if (cmd_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          pending   = 1'b0;
          cmd_seen++;
          last_addr = cmd_addr;
          last_data = cmd_data;
          prev_acc  = 1'b1;
        end
      end
      if (frame_err) begin
        chk("frame_err_expected", 32'(exp_ferr > 0), 32'd1);
        if (exp_ferr > 0) exp_ferr--;
        ferr_seen++;
      end
      if (chk_err) begin
        chk("chk_err_expected", 32'(exp_chk > 0), 32'd1);
        if (exp_chk > 0) exp_chk--;
        chk_seen++;
      end
      if (overrun) begin
        chk("overrun_expected", 32'(exp_ovr > 0), 32'd1);
        if (exp_ovr > 0) exp_ovr--;
        ovr_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    model_byte(b, stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    if (!stop_bit) drive_bit(1'b1);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(HDR, 1'b1);
    send_byte(a, 1'b1);
    send_byte(d, 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic idle_bits(input int n);
    if (n > int'(TIMEOUT_BITS) && !pending) pkt.delete();
    rxd = 1'b1;
    repeat (n * CPB) tick();
  endtask

  task automatic drain(input string name);
    chk({name, "_cmds_done"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_ferr_done"}, 32'(exp_ferr), 32'd0);
    chk({name, "_chk_done"}, 32'(exp_chk), 32'd0);
    chk({name, "_ovr_done"}, 32'(exp_ovr), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_valid"}, 32'(cmd_valid), 32'd0);
    chk({name, "_addr"}, 32'(cmd_addr), 32'd0);
    chk({name, "_data"}, 32'(cmd_data), 32'd0);
    chk({name, "_ferr"}, 32'(frame_err), 32'd0);
    chk({name, "_chkerr"}, 32'(chk_err), 32'd0);
    chk({name, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  int c0, k0, o0, f0;

  initial begin
    rst_n     = 1'b0;
    rxd       = 1'b1;
    cmd_ready = 1'b1;
    model_reset();
    repeat (4) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle_bits(2);

    // Basic packet, downstream always ready
    c0 = cmd_seen; k0 = chk_seen;
    send_pkt(8'h12, 8'h34, 8'h26);
    idle_bits(2);
    chk("basic_cmd_count", 32'(cmd_seen - c0), 32'd1);
    chk("basic_addr", 32'(last_addr), 32'h12);
    chk("basic_data", 32'(last_data), 32'h34);
    chk("basic_no_chkerr", 32'(chk_seen - k0), 32'd0);
    drain("basic");

    // Held command with an overrun byte
    cmd_ready = 1'b0;
    c0 = cmd_seen; o0 = ovr_seen;
    send_pkt(8'h3A, 8'h04, 8'h3E);
    idle_bits(2);
    chk("hold_model_front", 32'(exp_q[0]), 32'h3A04);
    chk("hold_valid", 32'(cmd_valid), 32'd1);
    chk("hold_addr", 32'(cmd_addr), 32'h3A);
    chk("hold_data", 32'(cmd_data), 32'h04);
    send_byte(8'h55, 1'b1);
    idle_bits(2);
    chk("hold_overrun_count", 32'(ovr_seen - o0), 32'd1);
    chk("hold_still_valid", 32'(cmd_valid), 32'd1);
    chk("hold_no_accept", 32'(cmd_seen - c0), 32'd0);
    cmd_ready = 1'b1;
    tick();
    tick();
    chk("hold_valid_dropped", 32'(cmd_valid), 32'd0);
    chk("hold_cmd_count", 32'(cmd_seen - c0), 32'd1);
    drain("hold");

    // Checksum error then good packet
    c0 = cmd_seen; k0 = chk_seen;
    send_pkt(8'h12, 8'h34, 8'h27);
    idle_bits(2);
    chk("chk_pulse_count", 32'(chk_seen - k0), 32'd1);
    chk("chk_no_cmd", 32'(cmd_seen - c0), 32'd0);
    send_pkt(8'h01, 8'h80, 8'h81);
    idle_bits(2);
    chk("chk_then_cmd", 32'(cmd_seen - c0), 32'd1);
    chk("chk_then_addr", 32'(last_addr), 32'h01);
    chk("chk_then_data", 32'(last_data), 32'h80);
    drain("chk");

    // Inter-byte timeout abandons partial packet
    c0 = cmd_seen; k0 = chk_seen;
    send_byte(HDR, 1'b1);
    send_byte(8'h12, 1'b1);
    idle_bits(25);
    send_byte(8'h34, 1'b1);
    send_byte(8'h26, 1'b1);
    idle_bits(2);
    chk("timeout_no_cmd", 32'(cmd_seen - c0), 32'd0);
    chk("timeout_no_chkerr", 32'(chk_seen - k0), 32'd0);
    send_pkt(8'h05, 8'h06, 8'h03);
    idle_bits(2);
    chk("timeout_then_cmd", 32'(cmd_seen - c0), 32'd1);
    chk("timeout_then_addr", 32'(last_addr), 32'h05);
    drain("timeout");

    // Framing error after header, then a glitch inside a packet
    c0 = cmd_seen; f0 = ferr_seen;
    send_byte(HDR, 1'b1);
    send_byte(8'h12, 1'b0);
    idle_bits(2);
    chk("ferr_pulse_count", 32'(ferr_seen - f0), 32'd1);
    send_pkt(8'h05, 8'h06, 8'h03);
    idle_bits(2);
    chk("ferr_then_cmd", 32'(cmd_seen - c0), 32'd1);
    send_byte(HDR, 1'b1);
    rxd = 1'b0;
    repeat (6) tick();
    idle_bits(2);
    send_byte(8'h07, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h0F, 1'b1);
    idle_bits(2);
    chk("glitch_cmd_count", 32'(cmd_seen - c0), 32'd2);
    chk("glitch_addr", 32'(last_addr), 32'h07);
    chk("glitch_data", 32'(last_data), 32'h08);
    chk("glitch_no_ferr", 32'(ferr_seen - f0), 32'd1);
    drain("ferr");

    // Reset mid-packet discards partial state
    c0 = cmd_seen;
    send_byte(HDR, 1'b1);
    send_byte(8'h12, 1'b1);
    rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    check_outputs_zero("midreset");
    rst_n = 1'b1;
    send_byte(8'h34, 1'b1);
    send_byte(8'h26, 1'b1);
    idle_bits(2);
    chk("midreset_no_cmd", 32'(cmd_seen - c0), 32'd0);
    drain("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
